// File: rtl/shift_deserializer_pkg.sv
// Shared constants, FSM state type and bit-order encodings for the serial-to-parallel path.
package universal_pkg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-in / word-out bundle between the deserializer and its producer/consumer.
interface shift_deserializer_if #(
    parameter int WIDTH = universal_pkg::WIDTH
) ();

    logic             bit_in;
    logic             bit_valid;
    logic             dir;
    logic             frame_sync;
    logic             ovf_clear;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overflow;

    modport master (
        output bit_in, bit_valid, dir, frame_sync, ovf_clear, out_ready,
        input  out_data, out_valid, busy, overflow
    );

    modport slave (
        input  bit_in, bit_valid, dir, frame_sync, ovf_clear, out_ready,
        output out_data, out_valid, busy, overflow
    );

endinterface

// File: rtl/shift_deserializer_word_fifo.sv
// Small word FIFO; a push into a full FIFO is accepted only if a pop happens in the same cycle.
module word_fifo #(
    parameter int WIDTH = universal_pkg::WIDTH,
    parameter int DEPTH = universal_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    import universal_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
        return (idx == AW'(DEPTH - 1)) ? '0 : idx + AW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_idx <= idx_inc(wr_idx);
            if (do_pop)  rd_idx <= idx_inc(rd_idx);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/shift_deserializer.sv
// Assembles WIDTH-bit words from a serial stream (MSB- or LSB-first) and queues them in word_fifo.
//   state | meaning
//   IDLE  | no partial word held, bit count 0
//   SHIFT | 1..WIDTH-1 bits of the current word held
module shift_deserializer #(
    parameter int WIDTH = universal_pkg::WIDTH,
    parameter int DEPTH = universal_pkg::DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_deserializer_if.slave  bus
);
    import universal_pkg::*;

    localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_base, shifted;
    logic             word_done;
    logic             pop;
    logic             full;
    logic             empty;
    logic             ovf_set;
    logic             overflow_q;

    // frame_sync restarts the word before the current bit is taken in.
    always_comb begin
        cnt_base   = bus.frame_sync ? '0 : cnt_q;
        shreg_base = bus.frame_sync ? '0 : shreg_q;
        if (bus.dir == DIR_LSB_FIRST)
            shifted = (shreg_base >> 1) | (WIDTH'(bus.bit_in) << (WIDTH - 1));
        else
            shifted = (shreg_base << 1) | WIDTH'(bus.bit_in);
        word_done = bus.bit_valid && (cnt_base == LAST);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.bit_valid) state_d = word_done ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (bus.bit_valid)       state_d = word_done ? IDLE : SHIFT;
                else if (bus.frame_sync) state_d = IDLE;
            end
        endcase
        if (bus.bit_valid) begin
            cnt_d   = word_done ? '0 : cnt_base + CNT_W'(1);
            shreg_d = word_done ? '0 : shifted;
        end else if (bus.frame_sync) begin
            cnt_d   = '0;
            shreg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            overflow_q <= ovf_set | (overflow_q & ~bus.ovf_clear);
        end
    end

    assign pop     = ~empty & bus.out_ready;
    assign ovf_set = word_done & full & ~pop;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (word_done),
        .push_data (shifted),
        .pop       (pop),
        .head_data (bus.out_data),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid = ~empty;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed vector table, corner-case sequences, random stream vs queue model.
module tb_shift_deserializer;

    localparam int W = universal_pkg::WIDTH;
    localparam int D = universal_pkg::DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    shift_deserializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic rst, bv, b, d, fs, oc, rdy;
        logic       ev;
        logic [3:0] ed;
        logic       eb, eo;
    } vec_t;

    vec_t tbl[$];

    // Reference model: bits of the current word, queued words, sticky flag.
    bit             m_part[$];
    logic [W-1:0]   m_fifo[$];
    bit             m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step(input logic r, bv, b, d, fs, oc, rdy);
        bit           pop, done, full_pre;
        logic [W-1:0] w;
        if (r) begin
            m_part.delete();
            m_fifo.delete();
            m_ovf = 0;
            return;
        end
        full_pre = (m_fifo.size() == D);
        pop      = (m_fifo.size() > 0) && rdy;
        done     = 0;
        w        = '0;
        if (fs) m_part.delete();
        if (bv) begin
            m_part.push_back(b);
            if (m_part.size() == W) begin
                done = 1;
                for (int i = 0; i < W; i++) begin
                    if (d) w[i] = m_part[i];
                    else   w[W-1-i] = m_part[i];
                end
                m_part.delete();
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (done && !(full_pre && !pop)) m_fifo.push_back(w);
        m_ovf = (done && full_pre && !pop) || (m_ovf && !oc);
    endtask

    task automatic model_check(input string tag);
        check({tag, " valid"}, bus.out_valid, m_fifo.size() > 0);
        check({tag, " data"},  bus.out_data,  (m_fifo.size() > 0) ? m_fifo[0] : '0);
        check({tag, " busy"},  bus.busy,      m_part.size() > 0);
        check({tag, " ovf"},   bus.overflow,  m_ovf);
    endtask

    task automatic step(input logic r, bv, b, d, fs, oc, rdy);
        model_step(r, bv, b, d, fs, oc, rdy);
        reset          = r;
        bus.bit_valid  = bv;
        bus.bit_in     = b;
        bus.dir        = d;
        bus.frame_sync = fs;
        bus.ovf_clear  = oc;
        bus.out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input logic oc);
        step(0, 0, 0, 0, 0, oc, rdy);
    endtask

    task automatic send_word(input logic [3:0] v, input logic d, input logic rdy_last, input logic oc_last);
        for (int i = 0; i < W; i++) begin
            logic bt;
            bt = d ? v[i] : v[W-1-i];
            if (i == W - 1) step(0, 1, bt, d, 0, oc_last, rdy_last);
            else            step(0, 1, bt, d, 0, 0, 0);
        end
    endtask

    task automatic add(input logic rst, bv, b, d, fs, oc, rdy, ev, input logic [3:0] ed, input logic eb, eo);
        vec_t v;
        v = '{rst, bv, b, d, fs, oc, rdy, ev, ed, eb, eo};
        tbl.push_back(v);
    endtask

    initial begin
        logic cur_dir;
        // rst bv b d fs oc rdy | valid data busy ovf
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);   // MSB-first 1,0,1,1
        add(0,1,0,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,0,0,1, 1,4'hB,0,0);   // no bypass: word shows after the edge
        add(0,0,0,0,0,0,1, 0,4'h0,0,0);
        add(0,1,1,1,0,0,1, 0,4'h0,1,0);   // LSB-first 1,0,1,1
        add(0,1,0,1,0,0,1, 0,4'h0,1,0);
        add(0,1,1,1,0,0,1, 0,4'h0,1,0);
        add(0,1,1,1,0,0,1, 1,4'hD,0,0);
        add(0,0,0,0,0,0,1, 0,4'h0,0,0);
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);   // prefix to be discarded
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,1,0,1, 0,4'h0,1,0);   // frame_sync with bit: new bit 0
        add(0,1,0,0,0,0,1, 0,4'h0,1,0);
        add(0,1,0,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,0,0,1, 1,4'h9,0,0);
        add(0,0,0,0,0,0,1, 0,4'h0,0,0);
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);
        add(0,0,0,0,1,0,1, 0,4'h0,0,0);   // frame_sync alone drops partial
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);
        add(0,0,0,0,0,0,1, 0,4'h0,1,0);   // gap holds state
        add(0,1,0,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,0,0,1, 0,4'h0,1,0);
        add(0,1,1,0,0,0,1, 1,4'hB,0,0);
        add(0,0,0,0,0,0,1, 0,4'h0,0,0);

        step(1, 1, 1, 0, 1, 0, 1);
        check("reset valid", bus.out_valid, 0);
        check("reset data",  bus.out_data,  0);
        check("reset busy",  bus.busy,      0);
        check("reset ovf",   bus.overflow,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].bv, tbl[i].b, tbl[i].d, tbl[i].fs, tbl[i].oc, tbl[i].rdy);
            check($sformatf("vec%0d valid", i), bus.out_valid, tbl[i].ev);
            check($sformatf("vec%0d data", i),  bus.out_data,  tbl[i].ed);
            check($sformatf("vec%0d busy", i),  bus.busy,      tbl[i].eb);
            check($sformatf("vec%0d ovf", i),   bus.overflow,  tbl[i].eo);
        end

        // Overflow: A,5 buffered, C dropped
        step(1, 0, 0, 0, 0, 0, 0);
        send_word(4'hA, 0, 0, 0);
        check("ovf A valid", bus.out_valid, 1);
        check("ovf A data",  bus.out_data,  4'hA);
        send_word(4'h5, 0, 0, 0);
        check("ovf 5 head",  bus.out_data,  4'hA);
        check("ovf 5 flag",  bus.overflow,  0);
        send_word(4'hC, 0, 0, 0);
        check("ovf C flag",  bus.overflow,  1);
        check("ovf C head",  bus.out_data,  4'hA);
        idle(1, 0);
        check("ovf pop1",    bus.out_data,  4'h5);
        idle(1, 0);
        check("ovf pop2",    bus.out_valid, 0);
        idle(0, 1);
        check("ovf clear",   bus.overflow,  0);

        // Full buffer, completion with a simultaneous pop
        step(1, 0, 0, 0, 0, 0, 0);
        send_word(4'hA, 0, 0, 0);
        send_word(4'h5, 0, 0, 0);
        send_word(4'h3, 0, 1, 0);
        check("fullpop ovf",   bus.overflow,  0);
        check("fullpop head",  bus.out_data,  4'h5);
        idle(1, 0);
        check("fullpop next",  bus.out_data,  4'h3);
        idle(1, 0);
        check("fullpop empty", bus.out_valid, 0);

        // Set beats clear, then reset mid-word with full buffer
        step(1, 0, 0, 0, 0, 0, 0);
        send_word(4'hA, 0, 0, 0);
        send_word(4'h5, 0, 0, 0);
        send_word(4'hC, 0, 0, 1);
        check("setwins ovf", bus.overflow, 1);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("midword busy", bus.busy, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        check("rst valid", bus.out_valid, 0);
        check("rst busy",  bus.busy,      0);
        check("rst ovf",   bus.overflow,  0);
        check("rst data",  bus.out_data,  0);
        send_word(4'h6, 0, 0, 0);
        check("post-rst valid", bus.out_valid, 1);
        check("post-rst data",  bus.out_data,  4'h6);

        // Random stream against the queue model
        step(1, 0, 0, 0, 0, 0, 0);
        cur_dir = 0;
        for (int c = 0; c < 1500; c++) begin
            logic r, bv, b, fs, oc, rdy;
            if (m_part.size() == 0 && $urandom_range(0, 3) == 0) cur_dir = ~cur_dir;
            r   = ($urandom_range(0, 99) == 0);
            bv  = ($urandom_range(0, 9) < 7);
            b   = $urandom_range(0, 1);
            fs  = ($urandom_range(0, 19) == 0);
            oc  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 4);
            step(r, bv, b, cur_dir, fs, oc, rdy);
            model_check($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter: WIDTH, 4, bits per assembled word (matches the universal shift register width).
REQ-002 Parameter: DEPTH, 2, output buffer entries (power of two).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: bit_in  input  1  serial data bit, driven from the upstream register's SR_output or SL_output.
REQ-006 Port: bit_valid  input  1  bit_in is valid this cycle.
REQ-007 Port: dir  input  1  order select: 0 = MSB first (right-shift stream), 1 = LSB first (left-shift stream).
REQ-008 Port: frame_sync  input  1  discard any partial word and restart at bit 0.
REQ-009 Port: ovf_clear  input  1  clear the sticky overflow flag.
REQ-010 Port: out_data  output  WIDTH  head word of the output buffer.
REQ-011 Port: out_valid  output  1  buffer non-empty.
REQ-012 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 Port: busy  output  1  partial word held (FSM in SHIFT).
REQ-014 Port: overflow  output  1  sticky: a completed word was dropped.

Function
REQ-015 The FSM SHALL have two states: IDLE (bit count 0) and SHIFT (1..WIDTH-1 bits held).
REQ-016 IDLE->SHIFT on an accepted bit; SHIFT->IDLE on the accepted bit that completes WIDTH bits, or on frame_sync without bit_valid.
REQ-017 dir=0: each accepted bit SHALL shift into the LSB with older bits moving toward the MSB, so the first bit lands in out_data[WIDTH-1].
REQ-018 dir=1: each accepted bit SHALL shift into the MSB with older bits moving toward the LSB, so the first bit lands in out_data[0].
REQ-019 dir SHALL be sampled per bit; dir changes mid-word are not supported and the resulting word value is undefined.
REQ-020 The bit count SHALL wrap from WIDTH-1 to 0 on word completion, with no idle cycle needed between words.
REQ-021 A completed word SHALL be written to the buffer at the same edge; out_valid SHALL assert in the following cycle (1-cycle latency from the last bit_valid).
REQ-022 The buffer is a FIFO; a pop occurs when out_valid & out_ready; out_data is stable while out_valid=1 and out_ready=0.
REQ-023 Buffer full, word completes, no pop: the word SHALL be dropped, the contents left unchanged, and overflow set.
REQ-024 Buffer full, word completes, pop in the same cycle: both SHALL occur, with no drop and occupancy unchanged.
REQ-025 Buffer empty: a push and an out_ready in the same cycle SHALL NOT bypass; the word appears the next cycle.
REQ-026 frame_sync together with bit_valid: the partial word SHALL be discarded and bit_in taken as bit 0 of a new word (state SHIFT, count 1; WIDTH=1 completes immediately).
REQ-027 frame_sync SHALL NOT affect buffer contents or overflow.
REQ-028 ovf_clear and a new overflow event in the same cycle: overflow SHALL remain 1 (set wins).
REQ-029 When bit_valid=0, the shifter and count SHALL hold.

Reset
REQ-030 On reset=1 at a clock edge, the FSM SHALL go to IDLE with count 0 and shifter 0.
REQ-031 On reset, the buffer SHALL be emptied, out_valid=0, out_data=0, busy=0 and overflow=0.
REQ-032 Reset SHALL dominate all other inputs in the same cycle, including mid-word and while the buffer is full.

Structure
REQ-033 The shared package universal_pkg SHALL hold WIDTH, DEPTH, the FSM state enum (IDLE, SHIFT) and the dir encodings (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1).
REQ-034 The buffer SHALL be a separate sub-module word_fifo (WIDTH, DEPTH; push/pop/full/empty; synchronous reset).
REQ-035 The shifter, counter and FSM SHALL reside in shift_deserializer.

Verification
REQ-036 dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> out_valid=1 the cycle after the 4th bit, out_data=4'b1011, then out_valid=0.
REQ-037 dir=1, same bits 1,0,1,1 -> out_data=4'b1101.
REQ-038 out_ready=0, three words streamed (A, 5, C) -> words A,5 buffered, C dropped, overflow=1; pop yields A then 5; ovf_clear -> overflow=0.
REQ-039 Buffer full with word 3 completing while out_ready=1 -> no drop, overflow=0, pop order preserved.
REQ-040 Two bits sent, then frame_sync with bit_valid (bit=1), then bits 0,0,1 (dir=0) -> single word 4'b1001; no word from the discarded prefix.
REQ-041 Reset asserted mid-word and with the buffer full -> next cycle out_valid=0, busy=0, overflow=0; the next 4 bits form a correct word.
